platform_collision: RTL and testbench
=====================================

Name: platform_collision

Overview:
- Downstream consumer of the platform generator's `platforms` / `platform_activation` arrays.
- Once per frame it scans all platform slots, one per clock, and checks whether the doodle's feet land on an active platform top while falling.
- Reports the landing platform index and top y to the doodle physics block, which then applies the bounce.
- Sits beside the renderer; both read the same platform arrays.

Parameters:
- N_PLAT, 93, number of platform slots.
- PLAT_W, 100, platform width in px.
- DOODLE_W, 80, doodle hitbox width in px.
- DOODLE_H, 80, doodle height in px; feet row = doodle_y + DOODLE_H.
- LAND_TOL, 16, max px feet may sit below a platform top and still count as landing.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low (asserted at 0).
- frame_tick  in  1  one-cycle strobe, start of frame scan.
- doodle_x  in  11  doodle left edge, unsigned.
- doodle_y  in  10  doodle top edge, unsigned.
- doodle_vy  in  10  signed vertical speed; >0 means falling.
- platforms  in  N_PLAT×2×11  signed; [i][0] = top y, [i][1] = left x.
- platform_activation  in  N_PLAT  1 = slot i is present.
- busy  out  1  scan in progress.
- scan_done  out  1  one-cycle pulse at end of every scan.
- land_valid  out  1  one-cycle pulse; landing found (coincides with scan_done).
- land_idx  out  7  index of landing platform; valid with land_valid.
- land_y  out  11  signed top y of landing platform; valid with land_valid.
- overrun  out  1  sticky: frame_tick arrived while not IDLE.
- land_count  out  16  landing counter (see Optional Feature).

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; idx 0; best-hit registers cleared.
- FSM: IDLE → SCAN → REPORT → IDLE.
- IDLE: on frame_tick=1, snapshot doodle_x/y/vy into registers, set idx=0, clear best-hit, go SCAN.
- SCAN, one slot per clock, idx 0..N_PLAT-1:
  - All compares are signed 12-bit: doodle_x/y zero-extended, platform fields sign-extended. Negative platform y (off-screen top) must compare correctly.
  - Slot i is a hit iff all of the following hold:
    - activation[i]=1;
    - snapshot vy > 0;
    - plat_x < dx + DOODLE_W;
    - dx < plat_x + PLAT_W;
    - plat_y <= feet;
    - feet <= plat_y + LAND_TOL.
  - Best hit = largest plat_y (top closest to feet). On equal plat_y, keep the lower index: replace only on strictly greater.
  - At idx = N_PLAT-1, go REPORT.
- REPORT (one clock):
  - Register scan_done=1.
  - land_valid=1 iff any hit, with land_idx and land_y from the best hit.
  - Return to IDLE.
- Latency: land_valid/scan_done are high in the cycle following edge N_PLAT+1, counted from the edge that sampled frame_tick. With N_PLAT=93 that is 94 edges later.
- busy=1 from the edge after frame_tick through REPORT inclusive.
- land_idx and land_y hold their last value until the next REPORT. land_valid and scan_done drop after one cycle.
- frame_tick while busy: ignored, no restart; overrun set sticky until reset.
- doodle_* inputs may change during a scan; only the snapshot is used. platforms and activation must be stable during a scan (guaranteed by the generator).
- rst asserted mid-scan: immediate return to IDLE, no report emitted.
- vy <= 0 (rising or still): scan still runs and scan_done pulses; land_valid stays 0.

Optional Feature:
- Macro: PLATFORM_COLLISION_LANDCOUNT_EN.
- Defined: land_count increments on every land_valid pulse, saturates at 16'hFFFF, and is cleared by reset.
- Undefined: land_count is tied to 0 and no counter logic is synthesised.

Decomposition:
- Shared package doodle_pkg holds:
  - constants N_PLAT, PLAT_W, PLAT_H;
  - typedefs coord_x_t (signed 11-bit) and coord_y_t;
  - enum coll_state_t {IDLE, SCAN, REPORT}.
- One natural combinational sub-module, platform_hit_check:
  - inputs: one platform's x, y, activation bit, plus the doodle snapshot;
  - output: the hit bit.
  - Reusable later for spring/monster collision.

Test Plan:
- Basic landing:
  - Stimulus: slot 5 active at (y=400, x=342); dx=360, dy=325 (feet 405), vy=+4; frame_tick.
  - Required: land_valid=1, land_idx=5, land_y=400, exactly 94 edges after tick; busy low afterwards.
- Rising doodle:
  - Stimulus: same geometry, vy=-6.
  - Required: scan_done=1 with land_valid=0.
- Tie-break:
  - Stimulus: slots 10 and 40 both at y=400, x=342; slot 20 at y=390, x=342; feet 405, vy=+4.
  - Required: land_idx=10, land_y=400.
- Edge misses:
  - Horizontal: dx=442 (dx+80 > 442 but dx = plat_x+100) → no hit.
  - Tolerance: feet=417 with plat_y=400 → no hit; feet=416 → hit.
- Negative y / inactive slot:
  - Stimulus: slot 0 at y=-10, active, feet=0 (dy clamps feet ≥ 80, so use LAND_TOL test override); slot 3 inactive but geometrically hit.
  - Required: slot 3 never reported.
- Overrun and reset:
  - Stimulus: second frame_tick 20 cycles into a scan.
  - Required: overrun=1, a single scan_done.
  - Stimulus: rst=0 at cycle 50 of a scan.
  - Required: all outputs 0 immediately, no report.
  - With PLATFORM_COLLISION_LANDCOUNT_EN defined: 3 landing frames → land_count=3.

Source files
------------

// File: rtl/doodle_pkg.sv
`default_nettype none
// ============================================================================
// Module   : doodle_pkg
// Purpose  : Shared constants, coordinate types and collision FSM encoding
//            for the doodle-jump platform blocks.
// Contents : N_PLAT, PLAT_W, PLAT_H, DOODLE_W, DOODLE_H, LAND_TOL,
//            coord_x_t / coord_y_t (signed 11-bit), coll_state_t.
// Revision : 1.0 - initial release
// ============================================================================
package doodle_pkg;
   localparam int N_PLAT   = 93;
   localparam int PLAT_W   = 100;
   localparam int PLAT_H   = 16;
   localparam int DOODLE_W = 80;
   localparam int DOODLE_H = 80;
   localparam int LAND_TOL = 16;

   typedef logic signed [10:0] coord_x_t;
   typedef logic signed [10:0] coord_y_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      REPORT = 2'd2
   } coll_state_t;
endpackage
`default_nettype wire

// File: rtl/platform_hit_check.sv
`default_nettype none
// ============================================================================
// Module   : platform_hit_check
// Purpose  : Combinational landing test of one platform against the doodle
//            snapshot. Reusable for other top-surface collisions.
// Ports    : i_plat_x/i_plat_y  platform left x / top y (signed)
//            i_active           platform slot present
//            i_dx/i_dy          doodle left x / top y (unsigned)
//            i_vy               doodle vertical speed (signed, >0 falling)
//            o_hit              feet land on this platform top
// Revision : 1.0 - initial release
// ============================================================================
module platform_hit_check
   import doodle_pkg::*;
#(
   parameter int PLAT_W   = doodle_pkg::PLAT_W,
   parameter int DOODLE_W = doodle_pkg::DOODLE_W,
   parameter int DOODLE_H = doodle_pkg::DOODLE_H,
   parameter int LAND_TOL = doodle_pkg::LAND_TOL
) (
   input  coord_x_t           i_plat_x,
   input  coord_y_t           i_plat_y,
   input  logic               i_active,
   input  logic [10:0]        i_dx,
   input  logic [9:0]         i_dy,
   input  logic signed [9:0]  i_vy,
   output logic               o_hit
);
   localparam logic signed [11:0] c_plat_w   = 12'(PLAT_W);
   localparam logic signed [11:0] c_doodle_w = 12'(DOODLE_W);
   localparam logic signed [11:0] c_doodle_h = 12'(DOODLE_H);
   localparam logic signed [11:0] c_land_tol = 12'(LAND_TOL);

   // Doodle coordinates are unsigned, platform fields signed: bring all of
   // them into one signed 12-bit domain so off-screen platforms compare right.
   logic signed [11:0] w_dx;
   logic signed [11:0] w_feet;
   logic signed [11:0] w_px;
   logic signed [11:0] w_py;

   assign w_dx   = $signed({1'b0, i_dx});
   assign w_feet = $signed({2'b00, i_dy}) + c_doodle_h;
   assign w_px   = {i_plat_x[10], i_plat_x};
   assign w_py   = {i_plat_y[10], i_plat_y};

   assign o_hit = i_active
               && (i_vy > 10'sd0)
               && (w_px < w_dx + c_doodle_w)
               && (w_dx < w_px + c_plat_w)
               && (w_py <= w_feet)
               && (w_feet <= w_py + c_land_tol);
endmodule
`default_nettype wire

// File: rtl/platform_collision.sv
`default_nettype none
// ============================================================================
// Module   : platform_collision
// Purpose  : Once per frame, scans every platform slot (one per clock) and
//            reports the platform the falling doodle lands on.
// Ports    : clk, rst (async, active-low), frame_tick (scan start strobe)
//            doodle_x/y/vy      doodle position and vertical speed
//            platforms          [i][0] = top y, [i][1] = left x (signed)
//            platform_activation slot present bits
//            busy, scan_done, land_valid, land_idx, land_y, overrun,
//            land_count
// Options  : PLATFORM_COLLISION_LANDCOUNT_EN - saturating landing counter on
//            land_count; otherwise land_count is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module platform_collision
   import doodle_pkg::*;
#(
   parameter int PLAT_W   = doodle_pkg::PLAT_W,
   parameter int DOODLE_W = doodle_pkg::DOODLE_W,
   parameter int DOODLE_H = doodle_pkg::DOODLE_H,
   parameter int LAND_TOL = doodle_pkg::LAND_TOL
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_tick,
   input  logic [10:0]        doodle_x,
   input  logic [9:0]         doodle_y,
   input  logic signed [9:0]  doodle_vy,
   input  coord_x_t           platforms [N_PLAT][2],
   input  logic [N_PLAT-1:0]  platform_activation,
   output logic               busy,
   output logic               scan_done,
   output logic               land_valid,
   output logic [6:0]         land_idx,
   output coord_y_t           land_y,
   output logic               overrun,
   output logic [15:0]        land_count
);
   coll_state_t        r_state;
   logic [10:0]        r_dx;
   logic [9:0]         r_dy;
   logic signed [9:0]  r_vy;
   logic [6:0]         r_idx;
   logic               r_best_vld;
   logic [6:0]         r_best_idx;
   coord_y_t           r_best_y;
   logic               r_busy;
   logic               r_scan_done;
   logic               r_land_valid;
   logic [6:0]         r_land_idx;
   coord_y_t           r_land_y;
   logic               r_overrun;

   coord_y_t           w_py;
   logic               w_hit;

   assign w_py = platforms[r_idx][0];

   platform_hit_check #(
      .PLAT_W   (PLAT_W),
      .DOODLE_W (DOODLE_W),
      .DOODLE_H (DOODLE_H),
      .LAND_TOL (LAND_TOL)
   ) u_hit (
      .i_plat_x (platforms[r_idx][1]),
      .i_plat_y (w_py),
      .i_active (platform_activation[r_idx]),
      .i_dx     (r_dx),
      .i_dy     (r_dy),
      .i_vy     (r_vy),
      .o_hit    (w_hit)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_dx         <= '0;
         r_dy         <= '0;
         r_vy         <= '0;
         r_idx        <= '0;
         r_best_vld   <= 1'b0;
         r_best_idx   <= '0;
         r_best_y     <= '0;
         r_busy       <= 1'b0;
         r_scan_done  <= 1'b0;
         r_land_valid <= 1'b0;
         r_land_idx   <= '0;
         r_land_y     <= '0;
         r_overrun    <= 1'b0;
      end else begin
         r_scan_done  <= 1'b0;
         r_land_valid <= 1'b0;
         // A tick during SCAN or REPORT is dropped, only flagged.
         if (frame_tick && (r_state != IDLE))
            r_overrun <= 1'b1;
         case (r_state)
            IDLE: begin
               if (frame_tick) begin
                  r_dx       <= doodle_x;
                  r_dy       <= doodle_y;
                  r_vy       <= doodle_vy;
                  r_idx      <= '0;
                  r_best_vld <= 1'b0;
                  r_best_idx <= '0;
                  r_best_y   <= '0;
                  r_busy     <= 1'b1;
                  r_state    <= SCAN;
               end
            end
            SCAN: begin
               // Strictly-greater replacement keeps the lowest index on ties.
               if (w_hit && (!r_best_vld || (w_py > r_best_y))) begin
                  r_best_vld <= 1'b1;
                  r_best_idx <= r_idx;
                  r_best_y   <= w_py;
               end
               if (r_idx == 7'(N_PLAT - 1))
                  r_state <= REPORT;
               else
                  r_idx <= r_idx + 7'd1;
            end
            REPORT: begin
               r_scan_done  <= 1'b1;
               r_land_valid <= r_best_vld;
               if (r_best_vld) begin
                  r_land_idx <= r_best_idx;
                  r_land_y   <= r_best_y;
               end
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy       = r_busy;
   assign scan_done  = r_scan_done;
   assign land_valid = r_land_valid;
   assign land_idx   = r_land_idx;
   assign land_y     = r_land_y;
   assign overrun    = r_overrun;

`ifdef PLATFORM_COLLISION_LANDCOUNT_EN
   logic [15:0] r_land_count;

   // Counts on the same edge that raises land_valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_land_count <= '0;
      else if ((r_state == REPORT) && r_best_vld && (r_land_count != 16'hFFFF))
         r_land_count <= r_land_count + 16'd1;
   end

   assign land_count = r_land_count;
`else
   assign land_count = 16'd0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_platform_collision.sv
`default_nettype none
// ============================================================================
// Module   : tb_platform_collision
// Purpose  : Self-checking bench for platform_collision. Expected landing
//            results are queued when a frame is started and compared when
//            scan_done is observed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_platform_collision;
   import doodle_pkg::*;

   typedef struct {
      logic       valid;
      logic [6:0] idx;
      coord_y_t   y;
   } exp_t;

   logic               clk;
   logic               rst;
   logic               frame_tick;
   logic [10:0]        doodle_x;
   logic [9:0]         doodle_y;
   logic signed [9:0]  doodle_vy;
   coord_x_t           plat [N_PLAT][2];
   logic [N_PLAT-1:0]  act;
   logic               busy;
   logic               scan_done;
   logic               land_valid;
   logic [6:0]         land_idx;
   coord_y_t           land_y;
   logic               overrun;
   logic [15:0]        land_count;

   int   checks;
   int   failures;
   int   exp_landings;
   exp_t sb[$];

   platform_collision dut (
      .clk                 (clk),
      .rst                 (rst),
      .frame_tick          (frame_tick),
      .doodle_x            (doodle_x),
      .doodle_y            (doodle_y),
      .doodle_vy           (doodle_vy),
      .platforms           (plat),
      .platform_activation (act),
      .busy                (busy),
      .scan_done           (scan_done),
      .land_valid          (land_valid),
      .land_idx            (land_idx),
      .land_y              (land_y),
      .overrun             (overrun),
      .land_count          (land_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_plats();
      for (int i = 0; i < N_PLAT; i++) begin
         plat[i][0] = '0;
         plat[i][1] = '0;
      end
      act = '0;
   endtask

   task automatic set_plat(input int i, input int y, input int x);
      plat[i][0] = 11'(y);
      plat[i][1] = 11'(x);
      act[i]     = 1'b1;
   endtask

   task automatic set_doodle(input int x, input int y, input int vy);
      doodle_x  = 11'(x);
      doodle_y  = 10'(y);
      doodle_vy = 10'(vy);
   endtask

   // Start one frame and check the report against the queued expectation.
   task automatic run_frame(input string tag, input logic v, input int idx, input int y);
      exp_t e;
      int   lat;
      logic got;
      e.valid = v;
      e.idx   = 7'(idx);
      e.y     = 11'(y);
      sb.push_back(e);
      @(negedge clk);
      frame_tick = 1'b1;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
      chk({tag, "_busy_start"}, 32'(busy), 32'd1);
      lat = 0;
      got = 1'b0;
      for (int n = 1; n <= 200; n++) begin
         @(posedge clk);
         #1;
         if (scan_done) begin
            lat = n;
            got = 1'b1;
            break;
         end
      end
      chk({tag, "_done_seen"}, 32'(got), 32'd1);
      e = sb.pop_front();
      chk({tag, "_latency"}, 32'(lat), 32'd94);
      chk({tag, "_valid"}, 32'(land_valid), 32'(e.valid));
      if (e.valid) begin
         chk({tag, "_idx"}, 32'(land_idx), 32'(e.idx));
         chk({tag, "_y"}, 32'(land_y), 32'(e.y));
         exp_landings++;
      end
      chk({tag, "_busy_end"}, 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      chk({tag, "_done_drop"}, 32'(scan_done), 32'd0);
      chk({tag, "_valid_drop"}, 32'(land_valid), 32'd0);
      if (e.valid)
         chk({tag, "_idx_hold"}, 32'(land_idx), 32'(e.idx));
   endtask

   initial begin
      int pulses;
      int first_lat;
      checks       = 0;
      failures     = 0;
      exp_landings = 0;
      rst          = 1'b0;
      frame_tick   = 1'b0;
      clear_plats();
      set_doodle(0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(scan_done), 32'd0);
      chk("rst_valid", 32'(land_valid), 32'd0);
      chk("rst_idx", 32'(land_idx), 32'd0);
      chk("rst_y", 32'(land_y), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_count", 32'(land_count), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Basic landing: feet 405 on top 400.
      set_plat(5, 400, 342);
      set_doodle(360, 325, 4);
      run_frame("basic", 1'b1, 5, 400);

      // Rising doodle never lands.
      set_doodle(360, 325, -6);
      run_frame("rising", 1'b0, 0, 0);

      // Tie-break: equal tops keep the lower index; lower top loses.
      clear_plats();
      set_plat(10, 400, 342);
      set_plat(40, 400, 342);
      set_plat(20, 390, 342);
      set_doodle(360, 325, 4);
      run_frame("tie", 1'b1, 10, 400);

      // Horizontal edges against a platform at x=342.
      clear_plats();
      set_plat(5, 400, 342);
      set_doodle(442, 325, 4);
      run_frame("right_miss", 1'b0, 0, 0);
      set_doodle(441, 325, 4);
      run_frame("right_hit", 1'b1, 5, 400);
      set_doodle(262, 325, 4);
      run_frame("left_miss", 1'b0, 0, 0);
      set_doodle(263, 325, 2);
      run_frame("left_hit", 1'b1, 5, 400);

      // Vertical tolerance window [400, 416].
      set_doodle(360, 337, 4);
      run_frame("tol_miss", 1'b0, 0, 0);
      set_doodle(360, 336, 4);
      run_frame("tol_hit", 1'b1, 5, 400);
      set_doodle(360, 319, 4);
      run_frame("above_miss", 1'b0, 0, 0);
      set_doodle(360, 320, 4);
      run_frame("top_hit", 1'b1, 5, 400);

      // Negative y slot is a miss, inactive slot is never reported.
      clear_plats();
      set_plat(0, -10, 0);
      set_plat(3, 70, 0);
      act[3] = 1'b0;
      set_doodle(0, 0, 4);
      run_frame("inactive", 1'b0, 0, 0);
      set_plat(4, 70, 0);
      run_frame("neg_y_pick", 1'b1, 4, 70);

      // Negative platform x overlapping a doodle at the left border.
      clear_plats();
      set_plat(7, 400, -50);
      set_doodle(0, 325, 4);
      run_frame("neg_x", 1'b1, 7, 400);

      // Overrun: second tick 20 cycles into the scan.
      clear_plats();
      set_plat(5, 400, 342);
      set_doodle(360, 325, 4);
      @(negedge clk);
      frame_tick = 1'b1;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
      pulses    = 0;
      first_lat = 0;
      for (int n = 1; n <= 220; n++) begin
         if (n == 20) frame_tick = 1'b1;
         if (n == 21) frame_tick = 1'b0;
         @(posedge clk);
         #1;
         if (scan_done) begin
            pulses++;
            if (first_lat == 0) begin
               first_lat = n;
               chk("ovr_valid", 32'(land_valid), 32'd1);
               exp_landings++;
            end
         end
      end
      chk("ovr_pulses", 32'(pulses), 32'd1);
      chk("ovr_latency", 32'(first_lat), 32'd94);
      chk("ovr_flag", 32'(overrun), 32'd1);

      // Async reset 50 cycles into a scan: everything clears, no report.
      @(negedge clk);
      frame_tick = 1'b1;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
      repeat (50) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      exp_landings = 0;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_idx", 32'(land_idx), 32'd0);
      chk("mid_rst_y", 32'(land_y), 32'd0);
      chk("mid_rst_overrun", 32'(overrun), 32'd0);
      chk("mid_rst_count", 32'(land_count), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      pulses = 0;
      for (int n = 0; n < 120; n++) begin
         @(posedge clk);
         #1;
         if (scan_done) pulses++;
      end
      chk("mid_rst_no_report", 32'(pulses), 32'd0);

      // Three landing frames after reset.
      run_frame("cnt1", 1'b1, 5, 400);
      run_frame("cnt2", 1'b1, 5, 400);
      run_frame("cnt3", 1'b1, 5, 400);
`ifdef PLATFORM_COLLISION_LANDCOUNT_EN
      chk("land_count", 32'(land_count), 32'(exp_landings));
`else
      chk("land_count", 32'(land_count), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
